// File: rtl/vga_pkg.sv
// Shared constants, register map and FSM encoding for the VGA fill engine.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned FB_DEPTH  = H_VISIBLE * V_VISIBLE;
    localparam int unsigned FB_ADDR_W = 19;
    localparam int unsigned X_W       = 10;
    localparam int unsigned Y_W       = 9;
    localparam int unsigned COLOR_W   = 3;
    localparam int unsigned BUS_AW    = 3;
    localparam int unsigned BUS_DW    = 32;

    localparam logic [BUS_AW-1:0] REG_X0    = 3'd0;
    localparam logic [BUS_AW-1:0] REG_Y0    = 3'd1;
    localparam logic [BUS_AW-1:0] REG_W     = 3'd2;
    localparam logic [BUS_AW-1:0] REG_H     = 3'd3;
    localparam logic [BUS_AW-1:0] REG_COLOR = 3'd4;
    localparam logic [BUS_AW-1:0] REG_CTRL  = 3'd5;
    localparam logic [BUS_AW-1:0] REG_PIXEL = 3'd6;

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_CLEAR_BIT  = 1;
    localparam int unsigned STAT_BUSY_BIT   = 0;
    localparam int unsigned STAT_DONE_BIT   = 1;
    localparam int unsigned STAT_ERR_BIT    = 2;
    localparam int unsigned PIX_COLOR_LSB   = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/vga_fill_engine_if.sv
// CPU register bus plus framebuffer write port of the fill engine.
interface vga_fill_engine_if;
    import vga_pkg::*;

    logic                 bus_we;
    logic [BUS_AW-1:0]    bus_addr;
    logic [BUS_DW-1:0]    bus_wdata;
    logic [BUS_DW-1:0]    bus_rdata;
    logic                 fb_we;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [COLOR_W-1:0]   fb_data;
    logic                 done_pulse;

    modport master (
        output bus_we, bus_addr, bus_wdata,
        input  bus_rdata, fb_we, fb_addr, fb_data, done_pulse
    );

    modport slave (
        input  bus_we, bus_addr, bus_wdata,
        output bus_rdata, fb_we, fb_addr, fb_data, done_pulse
    );
endinterface

// File: rtl/vga_fill_addr_gen.sv
// Clips the rectangle to the screen and walks it row by row, producing the
// address of the pixel that will be emitted in the following cycle.
module vga_fill_addr_gen
    import vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 advance,
    input  logic [X_W-1:0]       x0,
    input  logic [Y_W-1:0]       y0,
    input  logic [X_W-1:0]       w,
    input  logic [Y_W-1:0]       h,
    output logic                 empty_c,
    output logic                 last_c,
    output logic [FB_ADDR_W-1:0] addr_nxt_c
);

    logic [X_W:0]           x_room_c;
    logic [Y_W:0]           y_room_c;
    logic [X_W-1:0]         w_eff_c, w_eff_q, w_eff_d;
    logic [Y_W-1:0]         h_eff_c, h_eff_q, h_eff_d;
    logic [FB_ADDR_W-1:0]   row_base_c;
    logic [X_W-1:0]         col_q, col_d;
    logic [Y_W-1:0]         row_q, row_d;
    logic [FB_ADDR_W-1:0]   base_q, base_d;

    // Clip against the visible area; row_base is Y0*640+X0 via shifts.
    always_comb begin
        x_room_c   = (X_W+1)'(H_VISIBLE) - {1'b0, x0};
        y_room_c   = (Y_W+1)'(V_VISIBLE) - {1'b0, y0};
        w_eff_c    = ({1'b0, w} < x_room_c) ? w : x_room_c[X_W-1:0];
        h_eff_c    = ({1'b0, h} < y_room_c) ? h : y_room_c[Y_W-1:0];
        empty_c    = (x0 >= X_W'(H_VISIBLE)) || (y0 >= Y_W'(V_VISIBLE)) ||
                     (w == '0) || (h == '0);
        row_base_c = (FB_ADDR_W'(y0) << 9) + (FB_ADDR_W'(y0) << 7) + FB_ADDR_W'(x0);
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        w_eff_d = w_eff_q;
        h_eff_d = h_eff_q;
        if (load) begin
            col_d   = '0;
            row_d   = '0;
            base_d  = row_base_c;
            w_eff_d = w_eff_c;
            h_eff_d = h_eff_c;
        end else if (advance) begin
            if (col_q == w_eff_q - X_W'(1)) begin
                col_d  = '0;
                row_d  = row_q + Y_W'(1);
                base_d = base_q + FB_ADDR_W'(H_VISIBLE);
            end else begin
                col_d  = col_q + X_W'(1);
            end
        end
        last_c     = (col_q == w_eff_q - X_W'(1)) && (row_q == h_eff_q - Y_W'(1));
        addr_nxt_c = base_d + FB_ADDR_W'(col_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            w_eff_q <= '0;
            h_eff_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            w_eff_q <= w_eff_d;
            h_eff_q <= h_eff_d;
        end
    end

endmodule

// File: rtl/vga_fill_engine.sv
// Memory-mapped rectangle fill engine driving the VGA framebuffer write port;
// also forwards single CPU pixel writes while idle.
module vga_fill_engine
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    vga_fill_engine_if.slave bus
);

    logic [X_W-1:0]       x0_q, x0_d, w_q, w_d, sx0_q, sx0_d, sw_q, sw_d;
    logic [Y_W-1:0]       y0_q, y0_d, h_q, h_d, sy0_q, sy0_d, sh_q, sh_d;
    logic [COLOR_W-1:0]   color_q, color_d, scolor_q, scolor_d;
    logic                 done_q, done_d, err_q, err_d;
    state_e               state_q, state_d;
    logic                 fb_we_q, fb_we_d, done_pulse_q, done_pulse_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0]   fb_data_q, fb_data_d;

    logic                 start_c, clear_c, pix_wr_c, pix_ok_c;
    logic                 load_c, advance_c, empty_c, last_c;
    logic [FB_ADDR_W-1:0] pix_addr_c, addr_nxt_c;
    logic                 unused_c;

    assign unused_c = ^{bus.bus_wdata[31:27], bus.bus_wdata[23:19]};

    always_comb begin
        start_c    = bus.bus_we && (bus.bus_addr == REG_CTRL) && bus.bus_wdata[CTRL_START_BIT];
        clear_c    = bus.bus_we && (bus.bus_addr == REG_CTRL) && bus.bus_wdata[CTRL_CLEAR_BIT];
        pix_wr_c   = bus.bus_we && (bus.bus_addr == REG_PIXEL);
        pix_addr_c = bus.bus_wdata[FB_ADDR_W-1:0];
        pix_ok_c   = pix_wr_c && (state_q == ST_IDLE) && (pix_addr_c < FB_ADDR_W'(FB_DEPTH));
    end

    vga_fill_addr_gen u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .advance    (advance_c),
        .x0         (sx0_q),
        .y0         (sy0_q),
        .w          (sw_q),
        .h          (sh_q),
        .empty_c    (empty_c),
        .last_c     (last_c),
        .addr_nxt_c (addr_nxt_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_c) state_d = ST_SETUP;
            ST_SETUP: state_d = empty_c ? ST_DONE : ST_FILL;
            ST_FILL:  if (last_c) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so fb_we aligns with FILL.
    always_comb begin
        load_c       = (state_q == ST_SETUP);
        advance_c    = (state_q == ST_FILL);
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        done_pulse_d = (state_d == ST_DONE);
        if (state_d == ST_FILL) begin
            fb_we_d   = 1'b1;
            fb_addr_d = addr_nxt_c;
            fb_data_d = scolor_q;
        end else if (pix_ok_c) begin
            fb_we_d   = 1'b1;
            fb_addr_d = pix_addr_c;
            fb_data_d = bus.bus_wdata[PIX_COLOR_LSB +: COLOR_W];
        end
    end

    // Register file, shadows and sticky status.
    always_comb begin
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        color_d  = color_q;
        sx0_d    = sx0_q;
        sy0_d    = sy0_q;
        sw_d     = sw_q;
        sh_d     = sh_q;
        scolor_d = scolor_q;
        done_d   = done_q;
        err_d    = err_q;
        if (bus.bus_we) begin
            case (bus.bus_addr)
                REG_X0:    x0_d    = bus.bus_wdata[X_W-1:0];
                REG_Y0:    y0_d    = bus.bus_wdata[Y_W-1:0];
                REG_W:     w_d     = bus.bus_wdata[X_W-1:0];
                REG_H:     h_d     = bus.bus_wdata[Y_W-1:0];
                REG_COLOR: color_d = bus.bus_wdata[COLOR_W-1:0];
                default:   ;
            endcase
        end
        if ((state_q == ST_IDLE) && start_c) begin
            sx0_d    = x0_q;
            sy0_d    = y0_q;
            sw_d     = w_q;
            sh_d     = h_q;
            scolor_d = color_q;
        end
        if (clear_c) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (state_d == ST_DONE)    done_d = 1'b1;
        if (pix_wr_c && !pix_ok_c) err_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            color_q      <= '0;
            sx0_q        <= '0;
            sy0_q        <= '0;
            sw_q         <= '0;
            sh_q         <= '0;
            scolor_q     <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            w_q          <= w_d;
            h_q          <= h_d;
            color_q      <= color_d;
            sx0_q        <= sx0_d;
            sy0_q        <= sy0_d;
            sw_q         <= sw_d;
            sh_q         <= sh_d;
            scolor_q     <= scolor_d;
            done_q       <= done_d;
            err_q        <= err_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    // Combinational register read-back.
    always_comb begin
        bus.bus_rdata = '0;
        case (bus.bus_addr)
            REG_X0:    bus.bus_rdata = BUS_DW'(x0_q);
            REG_Y0:    bus.bus_rdata = BUS_DW'(y0_q);
            REG_W:     bus.bus_rdata = BUS_DW'(w_q);
            REG_H:     bus.bus_rdata = BUS_DW'(h_q);
            REG_COLOR: bus.bus_rdata = BUS_DW'(color_q);
            REG_CTRL: begin
                bus.bus_rdata[STAT_BUSY_BIT] = (state_q != ST_IDLE);
                bus.bus_rdata[STAT_DONE_BIT] = done_q;
                bus.bus_rdata[STAT_ERR_BIT]  = err_q;
            end
            default:   bus.bus_rdata = '0;
        endcase
    end

    assign bus.fb_we      = fb_we_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_data    = fb_data_q;
    assign bus.done_pulse = done_pulse_q;

endmodule

// File: tb/tb_vga_fill_engine.sv
// Directed plus randomized bench for vga_fill_engine against a rectangle model.
module tb_vga_fill_engine;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_fill_engine_if ifc ();
    vga_fill_engine dut (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        int rel;
        int addr;
        int data;
    } wr_t;

    int   cyc = 0;
    int   start_cyc = 0;
    int   last_cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    wr_t  wq[$];
    int   dq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every framebuffer write and done pulse, cycle-numbered from the start edge.
    always @(negedge clk) begin
        if (ifc.fb_we === 1'b1)
            wq.push_back('{cyc - start_cyc + 1, int'(ifc.fb_addr), int'(ifc.fb_data)});
        if (ifc.done_pulse === 1'b1)
            dq.push_back(cyc - start_cyc + 1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        ifc.bus_we    = 1'b1;
        ifc.bus_addr  = a;
        ifc.bus_wdata = d;
        @(posedge clk);
        #1;
        last_cyc      = cyc;
        ifc.bus_we    = 1'b0;
        ifc.bus_wdata = '0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        ifc.bus_addr = a;
        #1;
        d = ifc.bus_rdata;
    endtask

    task automatic program_rect(input int x0, input int y0, input int w, input int h, input int c);
        wr_reg(REG_X0, 32'(x0));
        wr_reg(REG_Y0, 32'(y0));
        wr_reg(REG_W, 32'(w));
        wr_reg(REG_H, 32'(h));
        wr_reg(REG_COLOR, 32'(c));
    endtask

    // Start a fill, optionally poke PIXEL while busy, then compare against the model.
    task automatic run_fill(input string tag, input int x0, input int y0, input int w,
                            input int h, input int c, input bit pix_during);
        int exp_a[$];
        logic [31:0] st;
        int n;
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                if (x < 640 && y < 480) exp_a.push_back(y * 640 + x);
        n = exp_a.size();
        program_rect(x0, y0, w, h, c);
        wq.delete();
        dq.delete();
        wr_reg(REG_CTRL, 32'h1);
        start_cyc = last_cyc;
        if (pix_during) wr_reg(REG_PIXEL, 32'(55) | (32'(1) << 24));
        for (int i = 0; i < n + 40 && dq.size() == 0; i++) @(posedge clk);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_wcount"}, wq.size(), n);
        check({tag, "_donecount"}, dq.size(), 1);
        if (dq.size() > 0) check({tag, "_donecyc"}, dq[0], n + 2);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check({tag, "_addr"}, wq[i].addr, exp_a[i]);
            check({tag, "_data"}, wq[i].data, c);
            check({tag, "_wcyc"}, wq[i].rel, i + 2);
        end
        rd_reg(REG_CTRL, st);
        check({tag, "_busy"}, st[STAT_BUSY_BIT], 0);
        check({tag, "_done"}, st[STAT_DONE_BIT], 1);
    endtask

    initial begin
        logic [31:0] rd;
        rst           = 1'b1;
        ifc.bus_we    = 1'b0;
        ifc.bus_addr  = '0;
        ifc.bus_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_fb_we", ifc.fb_we, 0);
        check("rst_fb_addr", ifc.fb_addr, 0);
        check("rst_fb_data", ifc.fb_data, 0);
        check("rst_done_pulse", ifc.done_pulse, 0);
        for (int a = 0; a < 8; a++) begin
            rd_reg(3'(a), rd);
            check("rst_rdata", rd, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        wr_reg(REG_X0, 32'hABCD_0123);
        rd_reg(REG_X0, rd);
        check("x0_mask", rd, 32'h123);

        run_fill("basic", 10, 5, 4, 2, 5, 1'b0);
        run_fill("clip", 638, 478, 5, 5, 3, 1'b0);
        run_fill("zero_w", 20, 20, 0, 7, 1, 1'b0);
        run_fill("offscreen", 700, 10, 5, 5, 2, 1'b0);
        run_fill("wide", 0, 440, 640, 480, 6, 1'b0);
        for (int k = 0; k < 8; k++)
            run_fill("rand", int'($urandom_range(0, 700)), int'($urandom_range(0, 500)),
                     int'($urandom_range(0, 24)), int'($urandom_range(0, 12)),
                     int'($urandom_range(0, 7)), 1'b0);

        // Idle PIXEL pass-through.
        wq.delete();
        wr_reg(REG_CTRL, 32'h2);
        wr_reg(REG_PIXEL, 32'(1234) | (32'(4) << 24));
        start_cyc = last_cyc;
        repeat (3) @(negedge clk);
        #1;
        check("pix_count", wq.size(), 1);
        if (wq.size() > 0) begin
            check("pix_addr", wq[0].addr, 1234);
            check("pix_data", wq[0].data, 4);
            check("pix_cyc", wq[0].rel, 1);
        end
        rd_reg(REG_CTRL, rd);
        check("pix_status", rd, 0);

        // PIXEL while busy is dropped.
        run_fill("busy_pix", 0, 0, 10, 10, 7, 1'b1);
        rd_reg(REG_CTRL, rd);
        check("busy_pix_err", rd[STAT_ERR_BIT], 1);

        // Out-of-range PIXEL while idle is dropped.
        wr_reg(REG_CTRL, 32'h2);
        wq.delete();
        wr_reg(REG_PIXEL, 32'(307200) | (32'(3) << 24));
        repeat (3) @(negedge clk);
        #1;
        check("oob_count", wq.size(), 0);
        rd_reg(REG_CTRL, rd);
        check("oob_err", rd[STAT_ERR_BIT], 1);
        wr_reg(REG_CTRL, 32'h2);
        rd_reg(REG_CTRL, rd);
        check("clear_status", rd, 0);

        // Reset in the middle of a fill.
        program_rect(3, 2, 20, 3, 1);
        wq.delete();
        wr_reg(REG_CTRL, 32'h1);
        start_cyc = last_cyc;
        for (int i = 0; i < 60 && wq.size() < 3; i++) begin
            @(negedge clk);
            #2;
        end
        check("mid_rst_writes", wq.size(), 3);
        rst = 1'b1;
        ifc.bus_addr = REG_CTRL;
        #1;
        check("mid_rst_fb_we", ifc.fb_we, 0);
        check("mid_rst_busy", ifc.bus_rdata[STAT_BUSY_BIT], 0);
        @(negedge clk);
        rst = 1'b0;
        run_fill("after_rst", 0, 0, 20, 3, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
